// File: rtl/dmi_arbiter.sv
// Purpose: arbitrates the single DMI port of the debug module between the JTAG DTM (m0)
//          and a secondary debug requester (m1); one transaction in flight at a time.
// Latency: request accepted in cycle T -> s_req_valid from T+1; DM response accepted in
//          cycle R -> mX_resp_valid from R+1; at least 4 cycles per transaction.
// Backpressure: s_req_* and mX_resp_* are held stable until their ready; the non-owner
//          master's request simply waits (no req_ready) until the arbiter is back in IDLE.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   m0_req_* / m1_req_*   request channel from each master (valid/ready/addr/op/data)
//   m0_resp_* / m1_resp_* response channel to each master (valid/ready/data/resp)
//   s_req_* / s_resp_*    single DMI channel towards the debug module
//   grant_id          owner of the current transaction (0 = m0, 1 = m1)
//   busy              arbiter is not in IDLE
//   timeout_err       sticky timeout flag (only with DMI_ARB_TIMEOUT_EN)
//
// Optional feature macro: DMI_ARB_TIMEOUT_EN -- bounds the wait for a DM response to
// TIMEOUT_CYCLES cycles, returning resp = 2 (failed) and setting timeout_err.

module dmi_arbiter #(
    parameter int ABITS          = 7,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_req_valid,
    output logic             m0_req_ready,
    input  logic [ABITS-1:0] m0_req_addr,
    input  logic [1:0]       m0_req_op,
    input  logic [31:0]      m0_req_data,
    output logic             m0_resp_valid,
    input  logic             m0_resp_ready,
    output logic [31:0]      m0_resp_data,
    output logic [1:0]       m0_resp_resp,

    input  logic             m1_req_valid,
    output logic             m1_req_ready,
    input  logic [ABITS-1:0] m1_req_addr,
    input  logic [1:0]       m1_req_op,
    input  logic [31:0]      m1_req_data,
    output logic             m1_resp_valid,
    input  logic             m1_resp_ready,
    output logic [31:0]      m1_resp_data,
    output logic [1:0]       m1_resp_resp,

    output logic             s_req_valid,
    input  logic             s_req_ready,
    output logic [ABITS-1:0] s_req_addr,
    output logic [1:0]       s_req_op,
    output logic [31:0]      s_req_data,
    input  logic             s_resp_valid,
    output logic             s_resp_ready,
    input  logic [31:0]      s_resp_data,
    input  logic [1:0]       s_resp_resp,

    output logic             grant_id,
    output logic             busy
`ifdef DMI_ARB_TIMEOUT_EN
    ,
    output logic             timeout_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_RESP   = 2'd2,
        S_RETURN = 2'd3
    } state_t;

    state_t             state;
    logic               rr_ptr;     // master favoured when both request together
    logic               owner;      // registered grant, drives grant_id
    logic [ABITS-1:0]   req_addr;
    logic [1:0]         req_op;
    logic [31:0]        req_data;
    logic [31:0]        rsp_data;
    logic [1:0]         rsp_code;

    logic               live;       // handshake outputs are suppressed while rst is high
    logic               pick;       // master that would be granted this IDLE cycle
    logic               accept;     // request handshake in IDLE
    logic               owner_rdy;  // owner's resp_ready

    assign live = !rst;

    // Contention goes to rr_ptr; otherwise whichever master is requesting.
    assign pick   = (m0_req_valid && m1_req_valid) ? rr_ptr : m1_req_valid;
    assign accept = live && (state == S_IDLE) && (m0_req_valid || m1_req_valid);

    assign m0_req_ready = live && (state == S_IDLE) && m0_req_valid && !pick;
    assign m1_req_ready = live && (state == S_IDLE) && m1_req_valid &&  pick;

    assign s_req_valid = live && (state == S_REQ);
    assign s_req_addr  = req_addr;
    assign s_req_op    = req_op;
    assign s_req_data  = req_data;

`ifdef DMI_ARB_TIMEOUT_EN
    // Also ready in IDLE so a DM response arriving after a timeout is drained and dropped.
    assign s_resp_ready = live && ((state == S_RESP) || (state == S_IDLE));
`else
    assign s_resp_ready = live && (state == S_RESP);
`endif

    // Responses are only ever visible to the master that issued the request.
    assign m0_resp_valid = live && (state == S_RETURN) && (owner == 1'b0);
    assign m1_resp_valid = live && (state == S_RETURN) && (owner == 1'b1);
    assign m0_resp_data  = (owner == 1'b0) ? rsp_data : 32'h0;
    assign m0_resp_resp  = (owner == 1'b0) ? rsp_code : 2'd0;
    assign m1_resp_data  = (owner == 1'b1) ? rsp_data : 32'h0;
    assign m1_resp_resp  = (owner == 1'b1) ? rsp_code : 2'd0;

    assign owner_rdy = owner ? m1_resp_ready : m0_resp_ready;

    assign grant_id = owner;
    assign busy     = (state != S_IDLE);

`ifdef DMI_ARB_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;     // RESP cycles seen without a DM response
`else
    // Keeps the timeout parameter referenced when the feature is compiled out.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= 1'b0;
            owner    <= 1'b0;
            req_addr <= '0;
            req_op   <= 2'd0;
            req_data <= 32'h0;
            rsp_data <= 32'h0;
            rsp_code <= 2'd0;
`ifdef DMI_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner    <= pick;
                        req_addr <= pick ? m1_req_addr : m0_req_addr;
                        req_op   <= pick ? m1_req_op   : m0_req_op;
                        req_data <= pick ? m1_req_data : m0_req_data;
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (s_req_ready) begin
                        state <= S_RESP;
`ifdef DMI_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                S_RESP: begin
                    if (s_resp_valid) begin
                        rsp_data <= s_resp_data;
                        rsp_code <= s_resp_resp;
                        state    <= S_RETURN;
                    end
`ifdef DMI_ARB_TIMEOUT_EN
                    // This cycle brings the count to TIMEOUT_CYCLES: give up.
                    else if (wait_cnt >= CNT_LAST) begin
                        rsp_data    <= 32'h0;
                        rsp_code    <= 2'd2;
                        timeout_err <= 1'b1;
                        state       <= S_RETURN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_RETURN: begin
                    if (owner_rdy) begin
                        rr_ptr <= ~owner;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_arbiter.sv
// Purpose: scoreboard bench for dmi_arbiter; stimulus pushes expected forwarded requests
//          and responses, a negedge monitor pops and compares on every handshake.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.

module tb_dmi_arbiter;
    localparam int ABITS = 7;

`ifdef DMI_ARB_TIMEOUT_EN
    localparam logic IDLE_RR = 1'b1;
`else
    localparam logic IDLE_RR = 1'b0;
`endif

    typedef struct packed {
        logic [ABITS-1:0] addr;
        logic [1:0]       op;
        logic [31:0]      data;
        logic             gid;
    } req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  code;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    logic m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
    logic [ABITS-1:0] m0_req_addr;
    logic [1:0]  m0_req_op, m0_resp_resp;
    logic [31:0] m0_req_data, m0_resp_data;
    logic m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
    logic [ABITS-1:0] m1_req_addr;
    logic [1:0]  m1_req_op, m1_resp_resp;
    logic [31:0] m1_req_data, m1_resp_data;
    logic s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
    logic [ABITS-1:0] s_req_addr;
    logic [1:0]  s_req_op, s_resp_resp;
    logic [31:0] s_req_data, s_resp_data;
    logic grant_id, busy;
`ifdef DMI_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    always #5 clk = ~clk;

    dmi_arbiter #(.ABITS(ABITS), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_op(m0_req_op), .m0_req_data(m0_req_data), .m0_resp_valid(m0_resp_valid),
        .m0_resp_ready(m0_resp_ready), .m0_resp_data(m0_resp_data), .m0_resp_resp(m0_resp_resp),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_op(m1_req_op), .m1_req_data(m1_req_data), .m1_resp_valid(m1_resp_valid),
        .m1_resp_ready(m1_resp_ready), .m1_resp_data(m1_resp_data), .m1_resp_resp(m1_resp_resp),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
        .s_req_op(s_req_op), .s_req_data(s_req_data), .s_resp_valid(s_resp_valid),
        .s_resp_ready(s_resp_ready), .s_resp_data(s_resp_data), .s_resp_resp(s_resp_resp),
        .grant_id(grant_id), .busy(busy)
`ifdef DMI_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    req_t exp_req[$];
    rsp_t exp_r0[$];
    rsp_t exp_r1[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic m, input logic v, input logic [ABITS-1:0] a,
                             input logic [1:0] op, input logic [31:0] d);
        if (m) begin
            m1_req_valid = v; m1_req_addr = a; m1_req_op = op; m1_req_data = d;
        end else begin
            m0_req_valid = v; m0_req_addr = a; m0_req_op = op; m0_req_data = d;
        end
    endtask

    task automatic set_rsp_ready(input logic m, input logic v);
        if (m) m1_resp_ready = v;
        else   m0_resp_ready = v;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        req_t r;
        rsp_t p;
        if (s_req_valid && s_req_ready) begin
            if (exp_req.size() == 0) chk("sreq_unexpected", 1, 0);
            else begin
                r = exp_req.pop_front();
                chk("sreq_addr", 64'(s_req_addr), 64'(r.addr));
                chk("sreq_op",   64'(s_req_op),   64'(r.op));
                chk("sreq_data", 64'(s_req_data), 64'(r.data));
                chk("sreq_gid",  64'(grant_id),   64'(r.gid));
            end
        end
        if (m0_resp_valid && m0_resp_ready) begin
            if (exp_r0.size() == 0) chk("m0_resp_unexpected", 1, 0);
            else begin
                p = exp_r0.pop_front();
                chk("m0_resp", {m0_resp_data, m0_resp_resp}, {p.data, p.code});
            end
        end
        if (m1_resp_valid && m1_resp_ready) begin
            if (exp_r1.size() == 0) chk("m1_resp_unexpected", 1, 0);
            else begin
                p = exp_r1.pop_front();
                chk("m1_resp", {m1_resp_data, m1_resp_resp}, {p.data, p.code});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk_reset(input string tag);
        chk({tag, "_hs"}, {m0_req_ready, m1_req_ready, s_req_valid, m0_resp_valid,
                           m1_resp_valid, grant_id, busy}, 7'b0);
        chk({tag, "_srr"}, s_resp_ready, IDLE_RR);
        chk({tag, "_sreq"}, {s_req_addr, s_req_op, s_req_data}, 0);
        chk({tag, "_r0"}, {m0_resp_data, m0_resp_resp}, 0);
        chk({tag, "_r1"}, {m1_resp_data, m1_resp_resp}, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset(tag);
        tick();
    endtask

    // One transaction from master m with only that master being granted; entered and left
    // at posedge+1 with the arbiter in IDLE. sstall = cycles of s_req_ready low in REQ,
    // rstall = cycles of mX_resp_ready low in RETURN.
    task automatic txn(input logic m, input logic [ABITS-1:0] a, input logic [1:0] op,
                       input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] rc,
                       input int sstall, input int rstall);
        drive_req(m, 1'b1, a, op, wd);
        s_req_ready = (sstall == 0);
        exp_req.push_back({a, op, wd, m});
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("acc_ready", m ? m1_req_ready : m0_req_ready, 1);
        chk("acc_other", m ? m0_req_ready : m1_req_ready, 0);
        tick();
        drive_req(m, 1'b0, ~a, ~op, ~wd);       // proves the request was latched
        for (int i = 0; i < sstall; i++) begin
            @(negedge clk);
            chk("req_hold", {s_req_valid, s_req_addr, s_req_op, s_req_data}, {1'b1, a, op, wd});
            chk("req_stall_noacc", {m0_req_ready, m1_req_ready}, 2'b00);
            tick();
        end
        s_req_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", s_req_valid, 1);
        chk("grant_id", grant_id, m);
        chk("busy_req", busy, 1);
        tick();
        s_req_ready = 1'b0;
        s_resp_valid = 1'b1;
        s_resp_data = rd;
        s_resp_resp = rc;
        if (m) exp_r1.push_back({rd, rc});
        else   exp_r0.push_back({rd, rc});
        @(negedge clk);
        chk("resp_ready", s_resp_ready, 1);
        chk("resp_wait_novld", {m0_resp_valid, m1_resp_valid}, 2'b00);
        tick();
        s_resp_valid = 1'b0;
        s_resp_data = $urandom;
        s_resp_resp = 2'($urandom);
        if (rstall > 0) set_rsp_ready(m, 1'b0);
        for (int i = 0; i < rstall; i++) begin
            @(negedge clk);
            if (m) chk("rsp_hold", {m1_resp_valid, m1_resp_data, m1_resp_resp}, {1'b1, rd, rc});
            else   chk("rsp_hold", {m0_resp_valid, m0_resp_data, m0_resp_resp}, {1'b1, rd, rc});
            chk("rsp_stall_noacc", {m0_req_ready, m1_req_ready}, 2'b00);
            tick();
        end
        set_rsp_ready(m, 1'b1);
        @(negedge clk);
        chk("rsp_valid", m ? m1_resp_valid : m0_resp_valid, 1);
        chk("rsp_other", m ? m0_resp_valid : m1_resp_valid, 0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        drive_req(1'b0, 1'b0, '0, 2'd0, 32'h0);
        drive_req(1'b1, 1'b0, '0, 2'd0, 32'h0);
        m0_resp_ready = 1'b1;
        m1_resp_ready = 1'b1;
        s_req_ready = 1'b0;
        s_resp_valid = 1'b0;
        s_resp_data = 32'h0;
        s_resp_resp = 2'd0;
        do_reset("reset");

        // m0 reads dmstatus; m1 writes dmcontrol
        txn(1'b0, 7'h11, 2'd1, 32'h0, 32'h00400382, 2'd0, 0, 0);
        txn(1'b1, 7'h10, 2'd2, 32'h80000001, 32'h0, 2'd0, 0, 0);

        // both masters request continuously after reset: m0, m1, m0, m1
        do_reset("reset2");
        drive_req(1'b0, 1'b1, 7'h01, 2'd1, 32'h000000A0);
        drive_req(1'b1, 1'b1, 7'h02, 2'd2, 32'h000000B1);
        s_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = k[0];
            @(negedge clk);
            chk("rr_grant", g ? m1_req_ready : m0_req_ready, 1);
            chk("rr_other", g ? m0_req_ready : m1_req_ready, 0);
            exp_req.push_back(g ? {7'h02, 2'd2, 32'h000000B1, 1'b1}
                                : {7'h01, 2'd1, 32'h000000A0, 1'b0});
            tick();
            @(negedge clk);
            chk("rr_req", {s_req_valid, busy, m0_req_ready, m1_req_ready}, 4'b1100);
            tick();
            s_resp_valid = 1'b1;
            s_resp_data = 32'hC0DE0000 + 32'(k);
            s_resp_resp = 2'd0;
            if (g) exp_r1.push_back({32'hC0DE0000 + 32'(k), 2'd0});
            else   exp_r0.push_back({32'hC0DE0000 + 32'(k), 2'd0});
            @(negedge clk);
            chk("rr_resp", {s_resp_ready, m0_req_ready, m1_req_ready}, 3'b100);
            tick();
            s_resp_valid = 1'b0;
            @(negedge clk);
            chk("rr_ret", {m0_resp_valid, m1_resp_valid}, g ? 2'b01 : 2'b10);
            tick();
        end
        drive_req(1'b0, 1'b0, '0, 2'd0, 32'h0);
        drive_req(1'b1, 1'b0, '0, 2'd0, 32'h0);
        s_req_ready = 1'b0;

        // DM stalls request 5 cycles; reserved op, busy response code
        txn(1'b1, 7'h04, 2'd3, 32'h00001234, 32'h000055AA, 2'd3, 5, 0);
        // m0 holds off its response 3 cycles while an m1 nop waits
        drive_req(1'b1, 1'b1, 7'h38, 2'd0, 32'hFEEDF00D);
        txn(1'b0, 7'h17, 2'd1, 32'h0, 32'h12345678, 2'd2, 0, 3);
        txn(1'b1, 7'h38, 2'd0, 32'hFEEDF00D, 32'h0, 2'd0, 0, 0);

        // reset while in RESP
        drive_req(1'b1, 1'b1, 7'h22, 2'd1, 32'h0);
        s_req_ready = 1'b1;
        exp_req.push_back({7'h22, 2'd1, 32'h0, 1'b1});
        @(negedge clk);
        chk("rst_acc", m1_req_ready, 1);
        tick();
        drive_req(1'b1, 1'b0, '0, 2'd0, 32'h0);
        @(negedge clk);
        chk("rst_req", s_req_valid, 1);
        tick();
        s_req_ready = 1'b0;
        @(negedge clk);
        chk("rst_in_resp", s_resp_ready, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        tick();
        s_resp_valid = 1'b1;
        s_resp_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_resp", {s_resp_ready, m0_resp_valid, m1_resp_valid, busy},
                {IDLE_RR, 3'b000});
            tick();
        end
        s_resp_valid = 1'b0;
        // rr_ptr back to m0 after reset: m0 wins over a pending m1
        drive_req(1'b1, 1'b1, 7'h05, 2'd2, 32'h0000000F);
        txn(1'b0, 7'h06, 2'd1, 32'h0, 32'hA5A5A5A5, 2'd0, 0, 0);
        txn(1'b1, 7'h05, 2'd2, 32'h0000000F, 32'h0, 2'd0, 0, 0);

        // DM never responds to an m1 read
        drive_req(1'b1, 1'b1, 7'h11, 2'd1, 32'h0);
        s_req_ready = 1'b1;
        exp_req.push_back({7'h11, 2'd1, 32'h0, 1'b1});
        @(negedge clk);
        chk("to_acc", m1_req_ready, 1);
        tick();
        drive_req(1'b1, 1'b0, '0, 2'd0, 32'h0);
        @(negedge clk);
        chk("to_req", s_req_valid, 1);
        tick();
        s_req_ready = 1'b0;
`ifdef DMI_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("to_wait", {busy, s_resp_ready, m1_resp_valid, timeout_err}, 4'b1100);
            tick();
        end
        exp_r1.push_back({32'h0, 2'd2});
        @(negedge clk);
        chk("to_vld", m1_resp_valid, 1);
        chk("to_err", timeout_err, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_idle", busy, 0);
            tick();
        end
        s_resp_valid = 1'b1;
        s_resp_data = 32'h00000BAD;
        @(negedge clk);
        chk("late_consumed", s_resp_ready, 1);
        tick();
        s_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_dropped", {m0_resp_valid, m1_resp_valid, busy}, 3'b000);
            tick();
        end
        chk("to_err_sticky", timeout_err, 1);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("no_timeout", {busy, s_resp_ready, m1_resp_valid}, 3'b110);
            tick();
        end
        do_reset("reset3");
`endif

        chk("sb_empty", 64'(exp_req.size() + exp_r0.size() + exp_r1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/dmi_arbiter.md
Name: dmi_arbiter

Overview:
Two-master arbiter sharing the debug module's single DMI port between the JTAG DTM (m0) and a secondary debug requester (m1, e.g. a UART debug bridge).
- Exactly one DMI transaction is in flight at a time.
- Each request is registered and forwarded to the DM, and the response is routed back only to the issuing master.
- Sits between the DTM/bridge and dm_top inside ibex_soc_example.

Parameters:
ABITS, 7, DMI address width (matches dtmcs.abits).
TIMEOUT_CYCLES, 255, RESP-state cycle limit; used only with DMI_ARB_TIMEOUT_EN; must be >= 1.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
m0_req_valid  input  1  m0 request valid (JTAG DTM)
m0_req_ready  output  1  m0 request accepted
m0_req_addr  input  ABITS  DMI address
m0_req_op  input  2  0 nop, 1 read, 2 write
m0_req_data  input  32  write data
m0_resp_valid  output  1  response to m0 valid
m0_resp_ready  input  1  m0 accepts response
m0_resp_data  output  32  read data
m0_resp_resp  output  2  0 ok, 2 failed, 3 busy
m1_*  (same nine ports, same directions/widths)  secondary master
s_req_valid  output  1  request to DM valid
s_req_ready  input  1  DM accepts request
s_req_addr  output  ABITS  forwarded address
s_req_op  output  2  forwarded op
s_req_data  output  32  forwarded data
s_resp_valid  input  1  DM response valid
s_resp_ready  output  1  arbiter accepts DM response
s_resp_data  input  32  DM read data
s_resp_resp  input  2  DM response code
grant_id  output  1  owner of current transaction (0 = m0, 1 = m1)
busy  output  1  state != IDLE

Behaviour:
- Reset state, applied on any cycle where rst = 1:
  - state IDLE, rr_ptr = 0 (m0 favoured), grant_id = 0, busy = 0.
  - All *_valid and *_ready outputs 0; all data/addr/op/resp outputs 0.
- FSM states: IDLE -> REQ -> RESP -> RETURN -> IDLE.
- IDLE:
  - Only one valid: grant that master.
  - Both valid: grant the master selected by rr_ptr.
  - mX_req_ready = 1 combinationally for the granted master only, and only in IDLE.
  - On the handshake: latch addr/op/data and grant_id, go to REQ.
- REQ:
  - s_req_valid = 1, with s_req_* driven from registers and held stable until s_req_ready.
  - On the handshake go to RESP.
  - Latency: request accepted in cycle T, so s_req_valid is first high in T+1.
- RESP:
  - s_resp_ready = 1.
  - On s_resp_valid: latch data and resp, go to RETURN.
- RETURN:
  - m[grant_id]_resp_valid = 1 with latched data/resp, held stable until m[grant_id]_resp_ready.
  - On the handshake: go to IDLE and set rr_ptr = ~grant_id.
  - Latency: DM response accepted in cycle R, so mX_resp_valid is first high in R+1.
- The non-owner master never sees resp_valid or req_ready while busy; its request waits (its valid stays asserted per handshake rules).
- Op values, including nop (0) and reserved (3), are forwarded unmodified; no address decoding.
- s_resp_ready = 0 outside RESP (stray DM responses are not consumed), except as stated under the optional feature.
- Minimum transaction length is 4 cycles (IDLE accept, REQ, RESP, RETURN), so back-to-back throughput is at most one transaction per 4 cycles.
- Reset mid-transaction:
  - The transaction is abandoned and no response is delivered.
  - All outputs return to reset values on the next cycle.

Optional Feature:
DMI_ARB_TIMEOUT_EN
- Defined:
  - An 8..32-bit counter clears on entry to RESP and increments each RESP cycle without s_resp_valid.
  - When the count reaches TIMEOUT_CYCLES, the arbiter goes to RETURN with data = 0, resp = 2 (failed).
  - s_resp_ready is also 1 in IDLE, so a late DM response is silently discarded.
  - Sticky output timeout_err (1 bit) is set on a timeout and cleared only by rst.
- Not defined:
  - No counter and no timeout_err port.
  - RESP waits indefinitely.

Test Plan:
1. m0 reads dmstatus (addr 0x11, op 1) with s_req_ready = 1, and DM returns data 0x00400382, resp 0 -> s_req_valid high the cycle after accept with addr 0x11; m0_resp_valid high the cycle after s_resp handshake with 0x00400382 / 0; m1_resp_valid stays 0.
2. m1 writes dmcontrol (addr 0x10, op 2, data 0x80000001) -> forwarded exactly; m1 receives resp 0; grant_id = 1 during the transaction.
3. m0 and m1 both hold valid continuously after reset for 4 transactions -> grant order is m0, m1, m0, m1; each transaction takes >= 4 cycles.
4. Backpressure:
   - s_req_ready low for 5 cycles -> s_req_* stable, and no mX_req_ready pulse.
   - m0_resp_ready low for 3 cycles -> response held stable, and the pending m1 request is not accepted until the handshake.
5. rst asserted for 1 cycle while in RESP -> next cycle all valids/readies 0, busy 0, rr_ptr 0; a later DM response is not forwarded to either master.
6. With DMI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, DM never responds to an m1 read -> after 16 RESP cycles m1 receives data 0, resp 2, and timeout_err = 1; a DM response 5 cycles later is consumed in IDLE and never reaches either master. Without the macro, busy stays 1 indefinitely.
